// File: rtl/rr_logging_bus_pack2unpack_pkg.sv
// Shared logging-bus helpers: channel-width encoding and elaboration-time offset arithmetic.
// Reused by the packer, the unpacker and the trace decoder.
package rr_logging_bus_pack2unpack_pkg;

    localparam int unsigned RR_CHANNEL_WIDTH_BITS = 8;
    localparam int unsigned RR_MAX_CHANNELS       = 32;

    // Channel widths zero-extended to a fixed size so helpers work for any channel count.
    typedef logic [RR_MAX_CHANNELS*RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;

    function automatic int unsigned get_width(input rr_widths_t widths, input int unsigned c);
        return 32'(widths[c*RR_CHANNEL_WIDTH_BITS +: RR_CHANNEL_WIDTH_BITS]);
    endfunction

    function automatic int unsigned get_offset(input rr_widths_t widths, input int unsigned c);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < c; j++) begin
            off += get_width(widths, j);
        end
        return off;
    endfunction

    function automatic int unsigned get_full_width(input rr_widths_t widths,
                                                   input int unsigned cnt);
        return get_offset(widths, cnt);
    endfunction

endpackage

// File: rtl/rr_unpack_stage.sv
// One elastic pipeline stage of the logb unpacker: extracts channels CH_LO..CH_HI-1 from the
// packed remainder and places them at their fixed offsets in the unpacked bus.
module rr_unpack_stage
    import rr_logging_bus_pack2unpack_pkg::*;
#(
    parameter int unsigned LOGB_CHANNEL_CNT = 4,
    parameter rr_widths_t  WIDTHS           = '0,
    parameter int unsigned FULL_WIDTH       = 120,
    parameter int unsigned OFFSET_WIDTH     = 7,
    parameter int unsigned CH_LO            = 0,
    parameter int unsigned CH_HI            = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_load,
    input  logic                        i_valid,
    input  logic [FULL_WIDTH-1:0]       i_rem,
    input  logic [OFFSET_WIDTH-1:0]     i_acc,
    input  logic [FULL_WIDTH-1:0]       i_bus,
    input  logic [LOGB_CHANNEL_CNT-1:0] i_map,
    input  logic [OFFSET_WIDTH-1:0]     i_len,
    output logic                        o_valid,
    output logic [FULL_WIDTH-1:0]       o_rem,
    output logic [OFFSET_WIDTH-1:0]     o_acc,
    output logic [FULL_WIDTH-1:0]       o_bus,
    output logic [LOGB_CHANNEL_CNT-1:0] o_map,
    output logic [OFFSET_WIDTH-1:0]     o_len
);

    logic                    r_valid;
    logic [FULL_WIDTH-1:0]   r_rem;
    logic [OFFSET_WIDTH-1:0] r_acc;
    logic [FULL_WIDTH-1:0]   r_bus;
    logic [LOGB_CHANNEL_CNT-1:0] r_map;
    logic [OFFSET_WIDTH-1:0] r_len;

    logic [FULL_WIDTH-1:0]   w_rem;
    logic [OFFSET_WIDTH-1:0] w_acc;
    logic [FULL_WIDTH-1:0]   w_bus;

    always_comb begin
        w_rem = i_rem;
        w_acc = i_acc;
        w_bus = i_bus;
        for (int unsigned c = CH_LO; c < CH_HI; c++) begin
            if (i_map[c]) begin
                // A width equal to FULL_WIDTH wraps the shift to zero, giving an all-ones mask.
                w_bus = w_bus | ((w_rem & ((FULL_WIDTH'(1) << get_width(WIDTHS, c))
                                           - FULL_WIDTH'(1))) << get_offset(WIDTHS, c));
                w_rem = w_rem >> get_width(WIDTHS, c);
                w_acc = w_acc + OFFSET_WIDTH'(get_width(WIDTHS, c));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_rem <= w_rem;
            r_acc <= w_acc;
            r_bus <= w_bus;
            r_map <= i_map;
            r_len <= i_len;
        end
    end

    assign o_valid = r_valid;
    assign o_rem   = r_rem;
    assign o_acc   = r_acc;
    assign o_bus   = r_bus;
    assign o_map   = r_map;
    assign o_len   = r_len;

endmodule

// File: rtl/rr_logging_bus_pack2unpack.sv
// Replay-side logb unpacker: re-expands a packed record to fixed channel offsets through an
// elastic pipeline, checking that consumed bits match the recorded length.
module rr_logging_bus_pack2unpack
    import rr_logging_bus_pack2unpack_pkg::*;
#(
    parameter int unsigned LOGB_CHANNEL_CNT = 4,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {8'd64, 8'd16, 8'd8, 8'd32},
    parameter int unsigned CH_PER_STAGE     = 2,
    localparam rr_widths_t  WIDTHS       = rr_widths_t'(CHANNEL_WIDTHS),
    localparam int unsigned FULL_WIDTH   = get_full_width(WIDTHS, LOGB_CHANNEL_CNT),
    localparam int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
    localparam int unsigned CPS_SAFE     = (CH_PER_STAGE < 1) ? 1 : CH_PER_STAGE,
    localparam int unsigned NSTAGES      = (LOGB_CHANNEL_CNT + CPS_SAFE - 1) / CPS_SAFE
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
    input  logic [FULL_WIDTH-1:0]       in_data,
    input  logic [OFFSET_WIDTH-1:0]     in_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid,
    output logic [FULL_WIDTH-1:0]       out_logb_data,
    output logic                        len_err,
    output logic [31:0]                 rec_cnt
);

    if (CH_PER_STAGE < 1) begin : g_err_cps
        $error("CH_PER_STAGE must be at least 1");
    end
    if (LOGB_CHANNEL_CNT > RR_MAX_CHANNELS) begin : g_err_cnt
        $error("LOGB_CHANNEL_CNT exceeds RR_MAX_CHANNELS");
    end
    for (genvar c = 0; c < LOGB_CHANNEL_CNT; c++) begin : g_chk_width
        if (CHANNEL_WIDTHS[c] == 0) begin : g_err_width
            $error("channel width must be non-zero");
        end
    end

    // Index 0 is the input side; index k+1 is the register output of stage k.
    logic [NSTAGES:0]            w_valid;
    logic [NSTAGES:0]            w_ready;
    logic [FULL_WIDTH-1:0]       w_rem [NSTAGES+1];
    logic [OFFSET_WIDTH-1:0]     w_acc [NSTAGES+1];
    logic [FULL_WIDTH-1:0]       w_bus [NSTAGES+1];
    logic [LOGB_CHANNEL_CNT-1:0] w_map [NSTAGES+1];
    logic [OFFSET_WIDTH-1:0]     w_len [NSTAGES+1];
    logic                        w_out_hs;
    logic                        w_unused_rem;

    logic        r_len_err;
    logic [31:0] r_rec_cnt;

    assign w_valid[0] = in_valid;
    assign w_rem[0]   = in_data;
    assign w_acc[0]   = '0;
    assign w_bus[0]   = '0;
    assign w_map[0]   = in_logb_valid;
    assign w_len[0]   = in_len;

    // Stall chain: w_ready[k] is the load enable of stage k.
    always_comb begin
        w_ready          = '0;
        w_ready[NSTAGES] = out_ready;
        for (int k = int'(NSTAGES) - 1; k >= 0; k--) begin
            w_ready[k] = !w_valid[k+1] || w_ready[k+1];
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int unsigned CH_LO = k * CPS_SAFE;
        localparam int unsigned CH_HI = ((k + 1) * CPS_SAFE > LOGB_CHANNEL_CNT) ?
                                        LOGB_CHANNEL_CNT : (k + 1) * CPS_SAFE;
        rr_unpack_stage #(
            .LOGB_CHANNEL_CNT(LOGB_CHANNEL_CNT),
            .WIDTHS          (WIDTHS),
            .FULL_WIDTH      (FULL_WIDTH),
            .OFFSET_WIDTH    (OFFSET_WIDTH),
            .CH_LO           (CH_LO),
            .CH_HI           (CH_HI)
        ) u_stage (
            .clk    (clk),
            .rstn   (rstn),
            .i_load (w_ready[k]),
            .i_valid(w_valid[k]),
            .i_rem  (w_rem[k]),
            .i_acc  (w_acc[k]),
            .i_bus  (w_bus[k]),
            .i_map  (w_map[k]),
            .i_len  (w_len[k]),
            .o_valid(w_valid[k+1]),
            .o_rem  (w_rem[k+1]),
            .o_acc  (w_acc[k+1]),
            .o_bus  (w_bus[k+1]),
            .o_map  (w_map[k+1]),
            .o_len  (w_len[k+1])
        );
    end

    assign w_out_hs     = w_valid[NSTAGES] && out_ready;
    assign w_unused_rem = ^w_rem[NSTAGES];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len_err <= 1'b0;
            r_rec_cnt <= '0;
        end else if (w_out_hs) begin
            r_rec_cnt <= r_rec_cnt + 32'd1;
            if (w_acc[NSTAGES] != w_len[NSTAGES]) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign in_ready       = w_ready[0];
    assign out_valid      = w_valid[NSTAGES];
    assign out_logb_valid = w_map[NSTAGES];
    assign out_logb_data  = w_bus[NSTAGES];
    assign len_err        = r_len_err;
    assign rec_cnt        = r_rec_cnt;

endmodule

// File: tb/tb_rr_logging_bus_pack2unpack.sv
// Directed bench for rr_logging_bus_pack2unpack: vector table plus stall and reset sequences.
module tb_rr_logging_bus_pack2unpack;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_logb_valid;
    logic [119:0] in_data;
    logic [6:0]   in_len;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_logb_valid;
    logic [119:0] out_logb_data;
    logic         len_err;
    logic [31:0]  rec_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]   map;
        logic [119:0] data;
        logic [6:0]   len;
        logic [119:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs [7];

    rr_logging_bus_pack2unpack u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_logb_valid (in_logb_valid),
        .in_data       (in_data),
        .in_len        (in_len),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_logb_valid(out_logb_valid),
        .out_logb_data (out_logb_data),
        .len_err       (len_err),
        .rec_cnt       (rec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [119:0] pat(input int i);
        return {64'h1000_0000_0000_0000 + 64'(i), 16'(16'hA000 + i), 8'(8'h50 + i),
                32'(32'hC000_0000 + i)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_len_err", len_err, 1'b0);
        check("reset_rec_cnt", rec_cnt, 32'd0);
    endtask

    // Sends one record into an idle pipeline and checks it arrives exactly two cycles later.
    task automatic apply_vec(input vec_t v, input int exp_cnt);
        int waited;
        @(negedge clk);
        in_valid      = 1'b1;
        in_logb_valid = v.map;
        in_data       = v.data;
        in_len        = v.len;
        waited        = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("vec_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {4{$urandom()}};
        in_len   = 7'($urandom());
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 20);
        check("vec_out_valid", out_valid, 1'b1);
        check("vec_latency", waited, 2);
        check("vec_data", out_logb_data, v.exp_data);
        check("vec_map", out_logb_valid, v.map);
        check("vec_rec_cnt_pre", rec_cnt, exp_cnt);
        @(negedge clk);
        check("vec_len_err", len_err, v.exp_err);
        check("vec_rec_cnt_post", rec_cnt, exp_cnt + 1);
        check("vec_drained", out_valid, 1'b0);
    endtask

    initial begin
        int   sent;
        int   recv;
        int   cyc;
        int   seen;
        logic in_hs;
        logic out_hs;
        logic saw_stall;
        vec_t tmp;

        rstn          = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        in_logb_valid = '0;
        in_data       = '0;
        in_len        = '0;

        vecs[0] = '{map: 4'b1111,
                    data: {64'h0123_4567_89AB_CDEF, 16'hBEEF, 8'h5A, 32'hDEAD_BEEF},
                    len: 7'd120,
                    exp_data: {64'h0123_4567_89AB_CDEF, 16'hBEEF, 8'h5A, 32'hDEAD_BEEF},
                    exp_err: 1'b0};
        vecs[1] = '{map: 4'b1010,
                    data: {{6{8'hE7}}, 64'h0000_0000_0000_CAFE, 8'h5A},
                    len: 7'd72,
                    exp_data: {64'h0000_0000_0000_CAFE, 16'h0, 8'h5A, 32'h0},
                    exp_err: 1'b0};
        vecs[2] = '{map: 4'b0000, data: {120{1'b1}}, len: 7'd0,
                    exp_data: 120'h0, exp_err: 1'b0};
        vecs[3] = '{map: 4'b0100, data: {{13{8'hA5}}, 16'h1234}, len: 7'd16,
                    exp_data: {64'h0, 16'h1234, 8'h0, 32'h0}, exp_err: 1'b0};
        vecs[4] = '{map: 4'b1001,
                    data: {{3{8'h77}}, 64'hFEDC_BA98_7654_3210, 32'h1122_3344},
                    len: 7'd96,
                    exp_data: {64'hFEDC_BA98_7654_3210, 16'h0, 8'h0, 32'h1122_3344},
                    exp_err: 1'b0};
        vecs[5] = '{map: 4'b0110, data: {{12{8'h3C}}, 16'h7E81, 8'hC3}, len: 7'd24,
                    exp_data: {64'h0, 16'h7E81, 8'hC3, 32'h0}, exp_err: 1'b0};
        // ch0 alone consumes 32 bits but the record claims 40.
        vecs[6] = '{map: 4'b0001, data: {{11{8'h00}}, 32'hCAFE_BABE}, len: 7'd40,
                    exp_data: {88'h0, 32'hCAFE_BABE}, exp_err: 1'b1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], i);
        end

        // Sticky error survives clean traffic.
        tmp         = vecs[0];
        tmp.exp_err = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_vec(tmp, 7 + i);
        end

        // Back-to-back stream with a consumer stall.
        do_reset();
        sent      = 0;
        recv      = 0;
        cyc       = 0;
        saw_stall = 1'b0;
        while (recv < 8 && cyc < 100) begin
            @(negedge clk);
            in_valid      = (sent < 8);
            in_logb_valid = 4'b1111;
            in_data       = pat(sent);
            in_len        = 7'd120;
            out_ready     = !(cyc >= 3 && cyc <= 6);
            #1;
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (!in_ready) saw_stall = 1'b1;
            if (out_hs) begin
                check("b2b_data", out_logb_data, pat(recv));
                recv++;
            end
            @(posedge clk);
            cyc++;
            if (in_hs) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("b2b_recv_count", recv, 8);
        check("b2b_sent_count", sent, 8);
        check("b2b_saw_stall", saw_stall, 1'b1);
        @(negedge clk);
        check("b2b_rec_cnt", rec_cnt, 32'd8);
        check("b2b_no_extra", out_valid, 1'b0);
        check("b2b_len_err", len_err, 1'b0);

        // Reset while two records are in flight.
        do_reset();
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_logb_valid = 4'b1111;
        in_len        = 7'd120;
        in_data       = pat(20);
        @(posedge clk);
        @(negedge clk);
        in_data = pat(21);
        #1;
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_mid_full", out_valid, 1'b1);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_rec_cnt", rec_cnt, 32'd0);
        check("rst_mid_in_ready2", in_ready, 1'b1);
        rstn      = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid_no_stale", seen, 0);
        check("rst_mid_rec_cnt2", rec_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_logging_bus_pack2unpack.md
Name: rr_logging_bus_pack2unpack

Overview:
- Inverse of the logging-bus packer, used on the replay side.
- Accepts one packed logb record per handshake:
  - per-channel valid bitmap (shuffled channel order);
  - variable-length data, with valid channels concatenated from bit 0 in ascending channel index, no gaps;
  - total length.
- Re-expands each valid channel's data to its fixed offset in an unpacked bus.
- Sits between the trace-buffer reader and the per-channel replay engines. It is an elastic valid/ready pipeline with a length-consistency check.

Parameters:
- LOGB_CHANNEL_CNT, 4, number of logb channels (shuffled order).
- CHANNEL_WIDTHS, {64,16,8,32}, packed [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0].
  - Literal order is {ch3,ch2,ch1,ch0}, so widths are ch0=32, ch1=8, ch2=16, ch3=64.
- CH_PER_STAGE, 2, channels extracted per pipeline stage.
- FULL_WIDTH, derived = sum(CHANNEL_WIDTHS) = 120. Localparam, not overridable.
- OFFSET_WIDTH, derived = $clog2(FULL_WIDTH+1) = 7.
- NSTAGES, derived = ceil(LOGB_CHANNEL_CNT/CH_PER_STAGE) = 2.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- in_valid  in  1  packed record present
- in_ready  out  1  packer input may advance
- in_logb_valid  in  LOGB_CHANNEL_CNT  per-channel valid bitmap
- in_data  in  FULL_WIDTH  packed data; bits at or above in_len are don't-care
- in_len  in  OFFSET_WIDTH  total valid bits
- out_valid  out  1  unpacked record present
- out_ready  in  1  consumer accepts
- out_logb_valid  out  LOGB_CHANNEL_CNT  bitmap, passed through unchanged
- out_logb_data  out  FULL_WIDTH  channel i at fixed offset GET_OFFSET(i); invalid channels are zero
- len_err  out  1  sticky: consumed length differed from in_len
- rec_cnt  out  32  records delivered (out_valid && out_ready)

Behaviour:
- Reset: out_valid=0, in_ready=1, len_err=0, rec_cnt=0, every stage valid flag=0. Stage data registers are not reset.
- Stage k (0..NSTAGES-1) registers the following:
  - valid_k;
  - remaining packed data rem_k, already shifted so the next channel starts at bit 0;
  - consumed-length accumulator acc_k (OFFSET_WIDTH);
  - partial unpacked bus;
  - bitmap;
  - in_len.
- Stage k handles channels c = k*CH_PER_STAGE .. min(LOGB_CHANNEL_CNT, (k+1)*CH_PER_STAGE)-1, in ascending order.
  - If bitmap[c]: place rem[0 +: W_c] at GET_OFFSET(c), shift rem right by W_c, add W_c to acc.
  - Else: the slot is zero and rem/acc are unchanged.
- Latency: NSTAGES cycles from input handshake to out_valid when the pipeline is not stalled. Throughput is 1 record/cycle.
- Handshake per stage:
  - ready_k = !valid_k || ready_{k+1}, where ready_{NSTAGES} = out_ready;
  - in_ready = ready_0;
  - a stage loads when its ready is high;
  - valid_k <= valid_{k-1} on load (in_valid for stage 0).
  - Data holds stable while valid && !ready. out_valid/out_logb_* are the last stage's registers.
- in_ready is combinational from out_ready through the stall chain. No skid buffer is used because it is not needed at this depth.
- Length check: on the output handshake, if acc_last != len_last then len_err <= 1. len_err stays set until reset. The record is still delivered.
- rec_cnt increments on each output handshake and wraps 2^32-1 -> 0.
- All-zero bitmap with in_len=0: forwarded with out_logb_data=0 and no error.
- Bitmap with no bits set but in_len≠0: len_err.
- Simultaneous input and output handshakes on a full pipeline: both occur, and occupancy is unchanged.
- Reset mid-operation: all in-flight records are dropped, with no partial output after rstn rises.
- GET_OFFSET(c) = sum of W_j for j<c (elaboration-time function).
- Elaboration $error checks:
  - CH_PER_STAGE < 1;
  - any width = 0.

Decomposition:
- Shared package/header holds RR_CHANNEL_WIDTH_BITS, the DEF_GET_OFFSET macro, and a GET_FULL_WIDTH(CHANNEL_WIDTHS) function. These are reused by the packer and the trace decoder.
- One natural sub-module, rr_unpack_stage: parameterized by its channel range, with the elastic register and extraction logic. The top instantiates NSTAGES of these in a generate loop and adds the length check and counter.

Test Plan:
- All 4 valid; in_data = {ch3=64'h0123_4567_89AB_CDEF, ch2=16'hBEEF, ch1=8'h5A, ch0=32'hDEAD_BEEF}; in_len=120 -> after 2 cycles out_logb_data[31:0]=DEADBEEF, [39:32]=5A, [55:40]=BEEF, [119:56]=0123456789ABCDEF; len_err=0.
- Bitmap 4'b1010; in_data[7:0]=8'h5A, in_data[71:8]=64'hCAFE; in_len=72 -> [39:32]=5A, [119:56]=CAFE, all other bits 0.
- Bitmap 4'b0001, in_len=40 -> record delivered, len_err=1 and stays 1 across 10 following clean records.
- Back-to-back 8 records with out_ready held 0 for cycles 3-6 -> in_ready falls once both stages are full, no record is lost or duplicated, order is preserved, rec_cnt=8.
- rstn deasserted for 1 cycle while 2 records are in flight -> out_valid=0 the next cycle, rec_cnt=0, no stale output afterwards.
- Bitmap 0, in_len=0 -> out_valid with data 0, len_err=0, rec_cnt increments.
